// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by 32-step LSB-first shift-add and divides by 32-step
// MSB-first restoring division on operand magnitudes, then fixes signs.
// Divide-by-zero and signed overflow skip iteration and finish in one cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [4:0]  iter_cnt;
  logic [2:0]  f3_q;
  logic [63:0] acc;
  logic [32:0] rem;
  logic [31:0] mag_op;
  logic        neg_res;
  logic        neg_rem;

  logic        is_div_in;
  logic        a_signed_in;
  logic        b_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic        div_zero_in;
  logic        div_ovf_in;
  logic        special_in;
  logic [31:0] special_res_in;

  logic [32:0] sum_hi;
  logic [63:0] mul_next;
  logic [32:0] shifted;
  logic        quo_bit;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] final_res;

  // Decode the incoming request: operand signedness, magnitudes and special divides
  always_comb begin
    is_div_in   = funct3[2];
    a_signed_in = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg_in    = a_signed_in & op_a[31];
    b_neg_in    = b_signed_in & op_b[31];
    mag_a_in    = a_neg_in ? (~op_a + 32'd1) : op_a;
    mag_b_in    = b_neg_in ? (~op_b + 32'd1) : op_b;
    div_zero_in = is_div_in & (op_b == 32'd0);
    div_ovf_in  = is_div_in & ~funct3[0] & (op_a == 32'h8000_0000) &
                  (op_b == 32'hFFFF_FFFF);
    special_in  = div_zero_in | div_ovf_in;
    if (div_zero_in) begin
      special_res_in = funct3[1] ? op_a : 32'hFFFF_FFFF;
    end else begin
      special_res_in = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration of both datapaths plus the sign-corrected final result
  always_comb begin
    sum_hi   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_op} : 33'd0);
    mul_next = {sum_hi, acc[31:1]};
    shifted  = {rem[31:0], acc[31]};
    quo_bit  = (shifted >= {1'b0, mag_op});
    rem_next = quo_bit ? (shifted - {1'b0, mag_op}) : shifted;
    quo_next = {acc[30:0], quo_bit};
    prod_fix = neg_res ? (~mul_next + 64'd1) : mul_next;
    quo_fix  = neg_res ? (~quo_next + 32'd1) : quo_next;
    rem_fix  = neg_rem ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
    if (f3_q[2]) begin
      final_res = f3_q[1] ? rem_fix : quo_fix;
    end else begin
      final_res = (f3_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = special_in ? DONE : CALC;
        CALC:    if (iter_cnt == 5'd31) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Busy decodes straight from the state register
  always_comb begin
    busy = (state != IDLE);
  end

  // Done pulses in the single cycle spent in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= (next_state == DONE);
    end
  end

  // Operand capture, iteration and result write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt <= 5'd0;
      f3_q     <= 3'd0;
      acc      <= 64'd0;
      rem      <= 33'd0;
      mag_op   <= 32'd0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= 32'd0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (start) begin
            f3_q     <= funct3;
            iter_cnt <= 5'd0;
            neg_res  <= a_neg_in ^ b_neg_in;
            neg_rem  <= a_neg_in;
            rem      <= 33'd0;
            if (is_div_in) begin
              acc    <= {32'd0, mag_a_in};
              mag_op <= mag_b_in;
            end else begin
              acc    <= {32'd0, mag_b_in};
              mag_op <= mag_a_in;
            end
            if (special_in) begin
              result <= special_res_in;
            end
          end
        end
        CALC: begin
          if (f3_q[2]) begin
            acc <= {acc[63:32], quo_next};
            rem <= rem_next;
          end else begin
            acc <= mul_next;
          end
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == 5'd31) begin
            result <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic reference model of the RV32M multiply/divide rules.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [31:0] last_result;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics via wide integer arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 ia;
    int                 ib;
    ia = a;
    ib = b;
    sa = {{32{a[31]}}, a};
    case (f3)
      3'b000, 3'b001: begin
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        return (f3 == 3'b000) ? sp[31:0] : sp[63:32];
      end
      3'b010: begin
        sb = {32'd0, b};
        sp = sa * sb;
        return sp[63:32];
      end
      3'b011: begin
        up = {32'd0, a} * {32'd0, b};
        return up[63:32];
      end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one op in the current IDLE cycle and check latency, result and return to idle
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
    int cycles;
    int exp_lat;
    exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
              ? 1 : 33;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    checkOutput({tag, ".busy"}, busy, 1);
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".latency"}, cycles, exp_lat);
    checkOutput({tag, ".result"}, result, exp);
    last_result = exp;
    @(negedge clk);
    checkOutput({tag, ".hold"}, result, exp);
    checkOutput({tag, ".idle"}, busy, 0);
    checkOutput({tag, ".pulse"}, done, 0);
  endtask

  // Count done pulses over a window where none should appear
  task automatic expectNoDone(input string tag, input int ncycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < ncycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput({tag, ".no_done"}, pulses, 0);
    checkOutput({tag, ".result_kept"}, result, last_result);
  endtask

  initial begin
    int          cycles;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;

    rst    = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    last_result = 32'd0;
    #12;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.result", result, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] directed multiply/divide");
    applyStimulus("mul_7x-3",  3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    applyStimulus("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    applyStimulus("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    applyStimulus("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    applyStimulus("div_-7/2",  3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    applyStimulus("rem_-7/2",  3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    applyStimulus("divu",      3'b101, 32'hFFFF_FFFE, 32'd3,         32'h5555_5554);
    applyStimulus("remu",      3'b111, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002);
    applyStimulus("div_by0",   3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF);
    applyStimulus("remu_by0",  3'b111, 32'd5,          32'd0,         32'd5);
    applyStimulus("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    applyStimulus("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    applyStimulus("mul_again", 3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);

    $display("[TB] flush at CALC cycle 10");
    funct3 = 3'b011;
    op_a   = 32'h1234_5678;
    op_b   = 32'h9ABC_DEF0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush.busy", busy, 0);
    checkOutput("flush.done", done, 0);
    expectNoDone("flush", 40);

    $display("[TB] start with flush in IDLE");
    funct3 = 3'b100;
    op_a   = 32'd5;
    op_b   = 32'd0;
    start  = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    flush  = 1'b0;
    checkOutput("startflush.busy", busy, 0);
    expectNoDone("startflush", 5);

    $display("[TB] start during CALC is ignored");
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    repeat (5) begin
      @(negedge clk);
      cycles++;
    end
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    cycles++;
    start  = 1'b0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("ignored.done", done, 1);
    checkOutput("ignored.latency", cycles, 33);
    checkOutput("ignored.result", result, refModel(3'b101, 32'd100, 32'd7));
    last_result = refModel(3'b101, 32'd100, 32'd7);
    @(negedge clk);
    checkOutput("ignored.idle", busy, 0);

    $display("[TB] reset mid-CALC");
    funct3 = 3'b000;
    op_a   = 32'd7;
    op_b   = 32'hFFFF_FFFD;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midreset.busy", busy, 0);
    checkOutput("midreset.done", done, 0);
    checkOutput("midreset.result", result, 0);
    last_result = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    expectNoDone("midreset", 40);

    $display("[TB] randomized ops");
    for (int i = 0; i < 60; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, refModel(rf3, ra, rb));
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
